pipeline_stall_flush_ctrl: RTL and testbench
============================================

Name: pipeline_stall_flush_ctrl

Overview:
- Pipeline control stage that consumes the hazard unit's load-use stall request, the X-stage branch/jump redirect, and the multdiv handshake.
- Produces the latch write-enables and NOP-inject selects for PC, FD, DX and XM.
- Owns the mult/div sequencing FSM: start pulse, wait-for-ready, timeout.
- Sits between the hazard detection unit and the pipeline latches in the processor top level.

Parameters:
- MD_TIMEOUT, 40, max cycles spent in MD_WAIT before forced abort.
- MD_CNT_W, 6, width of the multdiv wait counter; must satisfy 2^MD_CNT_W > MD_TIMEOUT.

Ports:
- clock  in  1  single pipeline clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- DX_Latch_Instr  in  32  instruction in DX; decoded for mul/div (opcode 5'd0, ALU op 5'd6 mul / 5'd7 div).
- DX_stalling_mux_select  in  1  load-use stall request from the hazard detection unit.
- X_branch_taken  in  1  branch/jump/jr/bex redirect resolved in X this cycle.
- md_result_ready  in  1  multdiv result valid.
- md_exception  in  1  multdiv error; valid only with md_result_ready.
- PC_enable  out  1  PC register write enable.
- PC_redirect_select  out  1  PC loads branch target.
- FD_enable  out  1  FD latch write enable.
- FD_nop_select  out  1  FD loads NOP (32'd0).
- DX_enable  out  1  DX latch write enable.
- DX_nop_select  out  1  DX loads NOP.
- XM_nop_select  out  1  XM loads NOP (bubble behind stalled mul/div).
- XM_md_result_select  out  1  XM O-latch takes the multdiv result instead of the ALU result.
- md_ctrl_mult  out  1  one-cycle mult start pulse.
- md_ctrl_div  out  1  one-cycle div start pulse.
- md_error_flag  out  1  error flag into the XM ErrorFlag latch.
- md_timeout_err  out  1  sticky; set on timeout abort.

Behaviour:
- States: IDLE, MD_WAIT. Reset value: IDLE, wait counter 0, md_timeout_err 0.
- All outputs are combinational from state and inputs.
- Defaults: all enables 1; all selects, pulses and flags 0. In reset, outputs take their IDLE default values.
- Priority order: redirect > multdiv > load-use.
- Redirect (X_branch_taken=1, any state except MD_WAIT):
  - PC_redirect_select=1, PC_enable=1.
  - FD_nop_select=1, DX_nop_select=1 (two-slot flush).
  - Mul/div in DX is squashed: no start pulse.
  - Load-use request ignored.
- IDLE, DX holds mul/div, no redirect:
  - md_ctrl_mult or md_ctrl_div = 1 for this cycle only.
  - PC_enable=FD_enable=DX_enable=0, XM_nop_select=1.
  - Counter cleared; next state MD_WAIT.
- MD_WAIT, md_result_ready=0:
  - Same stall as above plus XM_nop_select=1; counter increments.
  - X_branch_taken cannot assert here (DX holds mul/div); if asserted, it is ignored.
- MD_WAIT, md_result_ready=1:
  - All enables 1, XM_md_result_select=1, md_error_flag=md_exception.
  - Next state IDLE. DX advances the same edge, so no re-trigger.
- MD_WAIT, counter == MD_TIMEOUT with no ready:
  - Release as on ready, but md_error_flag=1 and md_timeout_err set (sticky until reset).
  - Next state IDLE.
- Load-use (IDLE, no redirect, no mul/div, DX_stalling_mux_select=1):
  - PC_enable=0, FD_enable=0, DX_nop_select=1; exactly one bubble per assertion cycle.
- Reset asserted mid-MD_WAIT: immediate return to IDLE, no pulse. A late md_result_ready after reset is ignored.
- Counter saturates; no wrap.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cycles[31:0] (counts cycles with PC_enable=0) and flush_count[31:0] (counts redirect cycles).
  - Both wrap at 2^32, clear on reset_n.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package/header pipe_ctrl_pkg holds:
  - opcode constants OPC_ALU=5'd0, OPC_LW=5'd8;
  - ALU op constants ALUOP_MUL=5'd6, ALUOP_DIV=5'd7;
  - NOP_INSTR=32'd0;
  - state encoding IDLE=1'b0, MD_WAIT=1'b1.
- One sub-module, md_wait_counter: clear, increment, saturate, and a terminal compare against MD_TIMEOUT.

Test Plan:
- Load-use: DX_stalling_mux_select=1 for one cycle → PC_enable=0, FD_enable=0, DX_nop_select=1 that cycle only; the following cycle returns to defaults.
- Mult, ready after 4 cycles:
  - mult in DX → md_ctrl_mult=1 for exactly one cycle;
  - 4 cycles with enables 0 and XM_nop_select=1;
  - ready cycle: XM_md_result_select=1, all enables 1; state IDLE next.
- Div by zero: md_result_ready=1 with md_exception=1 after 3 cycles → md_error_flag=1 on the ready cycle; md_timeout_err stays 0.
- Timeout: div start, never ready → after 40 wait cycles, release with md_error_flag=1 and md_timeout_err=1 held until reset.
- Simultaneous: X_branch_taken=1 with DX_stalling_mux_select=1 and mult in DX → PC_redirect_select=1, FD/DX NOP, no md_ctrl_mult, PC_enable=1.
- Reset mid-wait: reset_n low during MD_WAIT cycle 2 → outputs at defaults immediately; md_result_ready after release causes no XM_md_result_select.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, state encoding and the mul/div decode helper for the pipeline control stage.
package pipe_ctrl_pkg;

    localparam logic [4:0]  OPC_ALU   = 5'd0;
    localparam logic [4:0]  OPC_LW    = 5'd8;
    localparam logic [4:0]  ALUOP_MUL = 5'd6;
    localparam logic [4:0]  ALUOP_DIV = 5'd7;
    localparam logic [31:0] NOP_INSTR = 32'd0;

    typedef enum logic {
        IDLE    = 1'b0,
        MD_WAIT = 1'b1
    } md_state_e;

    // Returns {is_div, is_mul} for an instruction's opcode and ALU op fields.
    function automatic logic [1:0] md_decode(input logic [4:0] opcode, input logic [4:0] alu_op);
        logic [1:0] kind;
        kind = 2'b00;
        if (opcode == OPC_ALU) begin
            if (alu_op == ALUOP_MUL) begin
                kind = 2'b01;
            end else if (alu_op == ALUOP_DIV) begin
                kind = 2'b10;
            end else begin
                kind = 2'b00;
            end
        end else begin
            kind = 2'b00;
        end
        return kind;
    endfunction

endpackage

// File: rtl/md_wait_counter.sv
// Multdiv wait counter: clear, saturating increment and terminal compare against MD_TIMEOUT.
module md_wait_counter #(
    parameter int MD_TIMEOUT = 40,
    parameter int MD_CNT_W   = 6
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                inc,
    output logic [MD_CNT_W-1:0] count,
    output logic                terminal
);

    localparam logic [MD_CNT_W-1:0] CNT_MAX  = {MD_CNT_W{1'b1}};
    localparam logic [MD_CNT_W-1:0] CNT_TERM = MD_CNT_W'(MD_TIMEOUT);
    localparam logic [MD_CNT_W-1:0] CNT_ONE  = MD_CNT_W'(1);

    // Wait-cycle count; holds at all-ones rather than wrapping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end else begin
            count <= count;
        end
    end

    assign terminal = (count == CNT_TERM);

endmodule

// File: rtl/pipeline_stall_flush_ctrl.sv
// Pipeline stall/flush control with mul/div sequencing FSM.
// Optional PIPE_PERF_CNT_EN adds stall_cycles / flush_count performance counters.
module pipeline_stall_flush_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 40,
    parameter int MD_CNT_W   = 6
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] DX_Latch_Instr,
    input  logic        DX_stalling_mux_select,
    input  logic        X_branch_taken,
    input  logic        md_result_ready,
    input  logic        md_exception,
    output logic        PC_enable,
    output logic        PC_redirect_select,
    output logic        FD_enable,
    output logic        FD_nop_select,
    output logic        DX_enable,
    output logic        DX_nop_select,
    output logic        XM_nop_select,
    output logic        XM_md_result_select,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic        md_error_flag,
    output logic        md_timeout_err
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    md_state_e             state_r;
    md_state_e             state_nxt_s;
    logic [1:0]            md_kind_s;
    logic                  cnt_clear_s;
    logic                  cnt_inc_s;
    logic                  cnt_terminal_s;
    logic [MD_CNT_W-1:0]   cnt_value_s;
    logic                  set_timeout_s;
    logic                  flush_s;
    logic                  unused_instr_bits_s;

    assign md_kind_s           = md_decode(DX_Latch_Instr[31:27], DX_Latch_Instr[6:2]);
    assign unused_instr_bits_s = ^{DX_Latch_Instr[26:7], DX_Latch_Instr[1:0], cnt_value_s};

    md_wait_counter #(
        .MD_TIMEOUT (MD_TIMEOUT),
        .MD_CNT_W   (MD_CNT_W)
    ) u_md_wait_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (cnt_clear_s),
        .inc        (cnt_inc_s),
        .count      (cnt_value_s),
        .terminal   (cnt_terminal_s)
    );

    // Output and next-state decode; priority is redirect > multdiv > load-use, and reset forces defaults.
    always_comb begin
        PC_enable           = 1'b1;
        PC_redirect_select  = 1'b0;
        FD_enable           = 1'b1;
        FD_nop_select       = 1'b0;
        DX_enable           = 1'b1;
        DX_nop_select       = 1'b0;
        XM_nop_select       = 1'b0;
        XM_md_result_select = 1'b0;
        md_ctrl_mult        = 1'b0;
        md_ctrl_div         = 1'b0;
        md_error_flag       = 1'b0;
        cnt_clear_s         = 1'b0;
        cnt_inc_s           = 1'b0;
        set_timeout_s       = 1'b0;
        flush_s             = 1'b0;
        state_nxt_s         = state_r;
        if (!reset_n) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                MD_WAIT: begin
                    // A redirect cannot legally arrive while DX holds the mul/div, so it is ignored here.
                    if (md_result_ready) begin
                        XM_md_result_select = 1'b1;
                        md_error_flag       = md_exception;
                        state_nxt_s         = IDLE;
                    end else if (cnt_terminal_s) begin
                        XM_md_result_select = 1'b1;
                        md_error_flag       = 1'b1;
                        set_timeout_s       = 1'b1;
                        state_nxt_s         = IDLE;
                    end else begin
                        PC_enable     = 1'b0;
                        FD_enable     = 1'b0;
                        DX_enable     = 1'b0;
                        XM_nop_select = 1'b1;
                        cnt_inc_s     = 1'b1;
                    end
                end
                IDLE: begin
                    if (X_branch_taken) begin
                        PC_redirect_select = 1'b1;
                        FD_nop_select      = 1'b1;
                        DX_nop_select      = 1'b1;
                        flush_s            = 1'b1;
                    end else if (md_kind_s != 2'b00) begin
                        md_ctrl_mult  = md_kind_s[0];
                        md_ctrl_div   = md_kind_s[1];
                        PC_enable     = 1'b0;
                        FD_enable     = 1'b0;
                        DX_enable     = 1'b0;
                        XM_nop_select = 1'b1;
                        cnt_clear_s   = 1'b1;
                        state_nxt_s   = MD_WAIT;
                    end else if (DX_stalling_mux_select) begin
                        PC_enable     = 1'b0;
                        FD_enable     = 1'b0;
                        DX_nop_select = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // FSM state and sticky timeout flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            md_timeout_err <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            md_timeout_err <= md_timeout_err | set_timeout_s;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // Performance counters; both wrap naturally at 2^32.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            stall_cycles <= PC_enable ? stall_cycles : (stall_cycles + 32'd1);
            flush_count  <= flush_s ? (flush_count + 32'd1) : flush_count;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stall_flush_ctrl.sv
// Directed self-checking bench for pipeline_stall_flush_ctrl.
module tb_pipeline_stall_flush_ctrl;

    // Output vector order: PC_en, PC_redir, FD_en, FD_nop, DX_en, DX_nop, XM_nop, XM_mdres, mult, div, err, tmo
    localparam logic [11:0] O_DEF     = 12'b1010_1000_0000;
    localparam logic [11:0] O_LOADUSE = 12'b0000_1100_0000;
    localparam logic [11:0] O_MULSTRT = 12'b0000_0010_1000;
    localparam logic [11:0] O_DIVSTRT = 12'b0000_0010_0100;
    localparam logic [11:0] O_STALL   = 12'b0000_0010_0000;
    localparam logic [11:0] O_READY   = 12'b1010_1001_0000;
    localparam logic [11:0] O_RDYERR  = 12'b1010_1001_0010;
    localparam logic [11:0] O_REDIR   = 12'b1111_1100_0000;
    localparam logic [11:0] O_DEF_TMO = 12'b1010_1000_0001;

    localparam logic [31:0] I_ADD = 32'h0084_2000;
    localparam logic [31:0] I_MUL = 32'h0084_2018;
    localparam logic [31:0] I_DIV = 32'h0084_201C;
    localparam logic [31:0] I_LWX = 32'h4084_2018;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] DX_Latch_Instr;
    logic        DX_stalling_mux_select;
    logic        X_branch_taken;
    logic        md_result_ready;
    logic        md_exception;
    logic        PC_enable, PC_redirect_select, FD_enable, FD_nop_select;
    logic        DX_enable, DX_nop_select, XM_nop_select, XM_md_result_select;
    logic        md_ctrl_mult, md_ctrl_div, md_error_flag, md_timeout_err;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    pipeline_stall_flush_ctrl dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .DX_Latch_Instr         (DX_Latch_Instr),
        .DX_stalling_mux_select (DX_stalling_mux_select),
        .X_branch_taken         (X_branch_taken),
        .md_result_ready        (md_result_ready),
        .md_exception           (md_exception),
        .PC_enable              (PC_enable),
        .PC_redirect_select     (PC_redirect_select),
        .FD_enable              (FD_enable),
        .FD_nop_select          (FD_nop_select),
        .DX_enable              (DX_enable),
        .DX_nop_select          (DX_nop_select),
        .XM_nop_select          (XM_nop_select),
        .XM_md_result_select    (XM_md_result_select),
        .md_ctrl_mult           (md_ctrl_mult),
        .md_ctrl_div            (md_ctrl_div),
        .md_error_flag          (md_error_flag),
        .md_timeout_err         (md_timeout_err)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles           (stall_cycles),
        .flush_count            (flush_count)
`endif
    );

    wire [11:0] outs = {PC_enable, PC_redirect_select, FD_enable, FD_nop_select,
                        DX_enable, DX_nop_select, XM_nop_select, XM_md_result_select,
                        md_ctrl_mult, md_ctrl_div, md_error_flag, md_timeout_err};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic lu, input logic br,
                         input logic rdy, input logic exc);
        DX_Latch_Instr         = instr;
        DX_stalling_mux_select = lu;
        X_branch_taken         = br;
        md_result_ready        = rdy;
        md_exception           = exc;
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] exp);
        check(tag, {20'd0, outs}, {20'd0, exp});
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(I_MUL, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_defaults", O_DEF);
        step();
        step();
        reset_n = 1'b1;

        drive(I_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_add", O_DEF);
        step();
        drive(I_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("loaduse", O_LOADUSE);
        step();
        drive(I_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("loaduse_after", O_DEF);
        drive(I_LWX, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lw_not_md", O_DEF);
        step();

        // Mult, four wait cycles then ready
        drive(I_MUL, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mul_start", O_MULSTRT);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(I_MUL, 1'b0, (i == 2), 1'b0, 1'b0);
            chk("mul_wait", O_STALL);
            step();
        end
        drive(I_MUL, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("mul_ready", O_READY);
        step();
        drive(I_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mul_idle_after", O_DEF);
        step();

        // Divide by zero: exception on ready
        drive(I_DIV, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("div_start", O_DIVSTRT);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(I_DIV, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("div_wait", O_STALL);
            step();
        end
        drive(I_DIV, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("div_exc_ready", O_RDYERR);
        step();
        drive(I_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("div_exc_after", O_DEF);
        step();

        // Redirect beats mul/div and load-use
        drive(I_MUL, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("redirect_priority", O_REDIR);
        step();
        drive(I_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("redirect_after", O_DEF);
        step();

        // Reset in the middle of MD_WAIT
        drive(I_MUL, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_mul_start", O_MULSTRT);
        step();
        drive(I_MUL, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_wait1", O_STALL);
        step();
        drive(I_MUL, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_wait2", O_STALL);
        reset_n = 1'b0;
        #1;
        chk("rst_immediate", O_DEF);
        step();
        reset_n = 1'b1;
        drive(I_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_late_ready", O_DEF);
        step();

        // Timeout: div never completes
        drive(I_DIV, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tmo_start", O_DIVSTRT);
        step();
        for (int i = 0; i < 40; i++) begin
            drive(I_DIV, 1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("tmo_wait%0d", i), O_STALL);
            step();
        end
        drive(I_DIV, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tmo_release", O_RDYERR);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(I_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("tmo_sticky", O_DEF_TMO);
            step();
        end
        reset_n = 1'b0;
        #1;
        chk("tmo_cleared", O_DEF);
        step();
        reset_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
